// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the downstream system reset; retries on timeout or lock loss.
module pll_reset_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       soft_req,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic [3:0] fail_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_PLL_RESET = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  localparam logic [15:0] RST_LAST    = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  fail_q, fail_d;
  logic        sync1_q, locked_s_q;
  logic        fail_inc;

  // locked comes from the PLL's own timing domain; only locked_s_q is used
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= locked;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_PLL_RESET;
      cnt_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fail_inc = 1'b0;
    case (state_q)
      S_PLL_RESET: begin
        // soft_req is deliberately ignored here so the reset pulse is never stretched
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (soft_req) state_d = S_PLL_RESET;
        else if (locked_s_q) state_d = S_STABLE;
        else if (cnt_q == LOCK_LAST) begin
          state_d  = S_PLL_RESET;
          fail_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (soft_req) state_d = S_PLL_RESET;
        else if (!locked_s_q) state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (soft_req) state_d = S_PLL_RESET;
        else if (!locked_s_q) begin
          state_d  = S_PLL_RESET;
          fail_inc = 1'b1;
        end
      end
      default: state_d = S_PLL_RESET;
    endcase

    // counter restarts on every transition and idles at zero in RUN
    if ((state_d != state_q) || (state_q == S_RUN)) cnt_d = '0;
    else cnt_d = cnt_q + 16'd1;

    if (fail_inc && (fail_q != 4'hF)) fail_d = fail_q + 4'd1;
    else fail_d = fail_q;
  end

  always_comb begin
    pll_resetb  = (state_q != S_PLL_RESET);
    sys_reset_n = (state_q == S_RUN);
  end

  assign state      = state_q;
  assign fail_count = fail_q;

endmodule
